gray_ptr_hyper: RTL and testbench
=================================

Name: gray_ptr_hyper

Overview:
- Parametrised gray-coded FIFO pointer block for the uDMA HyperBus async FIFOs.
- Holds a local binary/gray pointer pair, synchronises the far-side gray pointer into the local clock, and produces the full flag (write side) or the empty flag (read side) plus a fill level.
- One instance sits on each side of a dual-clock FIFO. It replaces ad-hoc pointer logic built around the standalone binary/gray converters.

Parameters:
- ADDR_W, 3, FIFO address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits wide.
- MODE, 0, 0 = write side (flag_o means full); 1 = read side (flag_o means empty).
- SYNC_STAGES, 2, flops in the remote-pointer synchroniser; legal range 2..4.
- ALMOST_THR, 1, threshold for the almost flag (optional feature only); legal range 1..2**ADDR_W-1.

Ports:
- clk_i  in  1  local clock domain clock.
- rst_i  in  1  asynchronous, active-high reset.
- inc_i  in  1  request to advance the pointer by one entry (push or pop).
- remote_gray_i  in  ADDR_W+1  far-side gray pointer, registered in the far domain.
- ptr_gray_o  out  ADDR_W+1  local gray pointer, registered; sent to the far side.
- addr_o  out  ADDR_W  local RAM address (low ADDR_W bits of the binary pointer).
- flag_o  out  1  full (MODE=0) or empty (MODE=1).
- level_o  out  ADDR_W+1  occupancy as seen from this side, 0..2**ADDR_W.
- accept_o  out  1  inc_i accepted this cycle: inc_i & ~flag_o.

Behaviour:
- Reset (asynchronous, active-high): binary pointer, gray pointer and all synchroniser flops = 0.
  - Outputs after reset: ptr_gray_o=0, addr_o=0, level_o=0.
  - flag_o = 0 when MODE=0, 1 when MODE=1.
- Advance rule: on a clock edge with accept_o=1, bin <= bin+1, wrapping modulo 2**(ADDR_W+1).
  - gray <= (bin+1) ^ ((bin+1)>>1), registered from the same next value, so ptr_gray_o changes exactly one bit per advance and never glitches.
- inc_i with flag_o=1 is ignored: accept_o=0, pointer unchanged. No error indication.
- Latency:
  - inc_i accepted in cycle n -> ptr_gray_o and addr_o updated in cycle n+1.
  - remote_gray_i change -> visible in flag_o/level_o after SYNC_STAGES clock edges.
- Remote pointer path:
  - The synchroniser is a SYNC_STAGES-deep flop chain, reset 0, with no logic between stages.
  - The last stage is converted gray->binary combinationally: rbin[i] = XOR of rsync[ADDR_W:i].
- Level:
  - MODE=0: level_o = bin - rbin, modulo 2**(ADDR_W+1).
  - MODE=1: level_o = rbin - bin, modulo 2**(ADDR_W+1).
- Flags, combinational from registered state only (no path from inc_i):
  - MODE=0: flag_o = (level_o == 2**ADDR_W), i.e. ptr_gray equals rsync with the top two bits inverted.
  - MODE=1: flag_o = (ptr_gray == rsync).
- Conservativeness: the remote view lags, so the write side may report full late-clearing and the read side may report empty late-clearing. It must never report not-full/not-empty early.
- Wrap-around: the extra MSB distinguishes full from empty. After 2**(ADDR_W+1) advances the pointer returns to 0 with gray 0.
- Simultaneous events: a local advance and a remote change in the same cycle are both applied; flags recompute from the new values next cycle.
- Reset mid-operation: everything returns to reset values immediately, independent of clk_i. Both FIFO sides must be reset together; this is a system requirement, not checked in-block.

Optional Feature:
- Macro: GRAY_PTR_HYPER_ALMOST_EN.
- Defined:
  - Adds output almost_o (1 bit).
  - MODE=0: almost_o = (level_o >= 2**ADDR_W - ALMOST_THR).
  - MODE=1: almost_o = (level_o <= ALMOST_THR).
  - almost_o reset value follows from reset state: 0 for MODE=0, 1 for MODE=1.
- Undefined: port absent, ALMOST_THR unused, no extra logic.

Test Plan:
- ADDR_W=3, MODE=0, remote held 0; assert inc_i for 5 cycles -> ptr_gray_o=5'b00111, addr_o=5, level_o=5, flag_o=0.
- Same setup, continue to 8 accepts -> flag_o=1, level_o=8, ptr_gray_o=5'b01100. Further inc_i -> accept_o=0, pointer frozen.
- MODE=1, remote_gray_i stepped 0->1 (gray of 1) -> flag_o stays 1 for exactly 2 edges (SYNC_STAGES=2), then flag_o=0, level_o=1. One pop -> flag_o=1 next cycle.
- Wrap: MODE=0 with the remote tracking the local pointer after sync; perform 16 accepts -> ptr_gray_o returns to 0, gray sequence 1-bit Hamming distance at every step, flag_o never asserted.
- Async reset asserted mid-stream at level_o=6 between clock edges -> outputs at reset values immediately. After release, first accepted inc_i -> ptr_gray_o=5'b00001.
- With GRAY_PTR_HYPER_ALMOST_EN, ALMOST_THR=2, MODE=0 -> almost_o rises at level_o=6, falls when the remote advance drops level_o to 5.

Source files
------------

// File: rtl/gray_ptr_hyper.sv
// Gray-coded dual-clock FIFO pointer: local bin/gray pair, remote-pointer synchroniser, full/empty flag, fill level.
// Define GRAY_PTR_HYPER_ALMOST_EN to add the almost_o threshold flag.
module gray_ptr_hyper #(
  parameter int ADDR_W      = 3,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_THR  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic [ADDR_W:0]   remote_gray_i,
  output logic [ADDR_W:0]   ptr_gray_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              flag_o,
  output logic [ADDR_W:0]   level_o,
  output logic              accept_o
`ifdef GRAY_PTR_HYPER_ALMOST_EN
  ,
  output logic              almost_o
`endif
);

  localparam int PW = ADDR_W + 1;
  // Full when the gray pointers differ only in their top two bits.
  localparam logic [ADDR_W:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || ALMOST_THR < 1 || ALMOST_THR >= (1 << ADDR_W)) begin : g_illegal_params
  end

  logic [ADDR_W:0] r_bin;
  logic [ADDR_W:0] r_gray;
  logic [ADDR_W:0] r_sync [SYNC_STAGES];
  logic [ADDR_W:0] w_bin_nxt;
  logic [ADDR_W:0] w_rsync;
  logic [ADDR_W:0] w_rbin;
  logic [ADDR_W:0] w_level;
  logic            w_flag;

  assign w_bin_nxt = r_bin + PW'(1);
  assign accept_o  = inc_i & ~w_flag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else if (accept_o) begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_bin_nxt ^ (w_bin_nxt >> 1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= remote_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_rsync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ADDR_W; i++) w_rbin[i] = ^(w_rsync >> i);
  end

  if (MODE == 0) begin : g_wr_side
    assign w_level = r_bin - w_rbin;
    assign w_flag  = (r_gray == (w_rsync ^ FULL_MASK));
  end else begin : g_rd_side
    assign w_level = w_rbin - r_bin;
    assign w_flag  = (r_gray == w_rsync);
  end

`ifdef GRAY_PTR_HYPER_ALMOST_EN
  localparam logic [ADDR_W:0] ALMOST_HI = (PW'(1) << ADDR_W) - PW'(ALMOST_THR);
  if (MODE == 0) begin : g_almost_wr
    assign almost_o = (w_level >= ALMOST_HI);
  end else begin : g_almost_rd
    assign almost_o = (w_level <= PW'(ALMOST_THR));
  end
`endif

  assign ptr_gray_o = r_gray;
  assign addr_o     = r_bin[ADDR_W-1:0];
  assign flag_o     = w_flag;
  assign level_o    = w_level;

endmodule

// File: tb/tb_gray_ptr_hyper.sv
// Scoreboard bench for gray_ptr_hyper: write-side (MODE=0) and read-side (MODE=1) instances, ADDR_W=3.
module tb_gray_ptr_hyper;

  typedef struct {
    int    dut;
    string tag;
    int    gray;
    int    addr;
    int    flag;
    int    level;
    int    acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc0, inc1;
  logic [3:0] rem0, rem1;
  logic [3:0] gray0, gray1, lvl0, lvl1;
  logic [2:0] addr0, addr1;
  logic       flag0, flag1, acc0, acc1;
  logic       end_req;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Gray code of 0..15, worked by hand.
  int gtab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  always #5 clk = ~clk;

  gray_ptr_hyper #(.ADDR_W(3), .MODE(0), .SYNC_STAGES(2), .ALMOST_THR(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .inc_i(inc0), .remote_gray_i(rem0),
    .ptr_gray_o(gray0), .addr_o(addr0), .flag_o(flag0), .level_o(lvl0), .accept_o(acc0));

  gray_ptr_hyper #(.ADDR_W(3), .MODE(1), .SYNC_STAGES(2), .ALMOST_THR(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .inc_i(inc1), .remote_gray_i(rem1),
    .ptr_gray_o(gray1), .addr_o(addr1), .flag_o(flag1), .level_o(lvl1), .accept_o(acc1));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int d, string tag, int g, int a, int f, int l, int acc);
    exp_t e;
    e.dut = d; e.tag = tag; e.gray = g; e.addr = a; e.flag = f; e.level = l; e.acc = acc;
    q.push_back(e);
  endtask

  task automatic chk(string tag, string field, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0d expected=%0d at %0t", tag, field, act, exp, $time);
    end
  endtask

  // Monitor: compare every queued expectation against the outputs at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        chk(e.tag, "gray",  int'(gray0), e.gray);
        chk(e.tag, "addr",  int'(addr0), e.addr);
        chk(e.tag, "flag",  int'(flag0), e.flag);
        chk(e.tag, "level", int'(lvl0),  e.level);
        chk(e.tag, "accept", int'(acc0), e.acc);
      end else begin
        chk(e.tag, "gray",  int'(gray1), e.gray);
        chk(e.tag, "addr",  int'(addr1), e.addr);
        chk(e.tag, "flag",  int'(flag1), e.flag);
        chk(e.tag, "level", int'(lvl1),  e.level);
        chk(e.tag, "accept", int'(acc1), e.acc);
      end
    end
    if (end_req) begin
      if (checks < 12) begin
        errors++;
        $display("FAIL too_few_checks actual=%0d expected>=12", checks);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; inc0 = 1'b0; inc1 = 1'b0; rem0 = '0; rem1 = '0; end_req = 1'b0;
    #1;
    push(0, "rst", 0, 0, 0, 0, 0);
    push(1, "rst", 0, 0, 1, 0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    push(0, "rel", 0, 0, 0, 0, 0);

    // Fill the write side with remote held at 0; freeze once full.
    for (int k = 0; k < 10; k++) begin
      cyc();
      inc0 = 1'b1;
      if (k < 8) push(0, "fill", gtab[k], k, 0, k, 1);
      else       push(0, "full", gtab[8], 0, 1, 8, 0);
    end
    cyc();
    inc0 = 1'b0;

    // Read side: remote steps to 1, empty clears after two edges, one pop re-empties.
    cyc();
    rem1 = 4'd1;
    push(1, "empty_e0", 0, 0, 1, 0, 0);
    cyc();
    push(1, "empty_e1", 0, 0, 1, 0, 0);
    cyc();
    inc1 = 1'b1;
    push(1, "empty_e2", 0, 0, 0, 1, 1);
    cyc();
    inc1 = 1'b0;
    push(1, "pop", 1, 1, 1, 0, 0);

    // Reset, bring write side to level 6, then assert reset between edges.
    cyc();
    rem1 = '0;
    rst = 1'b1;
    push(0, "rst2", 0, 0, 0, 0, 0);
    push(1, "rst2", 0, 0, 1, 0, 0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      inc0 = (k < 6);
      push(0, "pre_rst", gtab[k], k, 0, k, (k < 6) ? 1 : 0);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    push(0, "async_rst", 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    push(0, "rel2", 0, 0, 0, 0, 0);
    cyc();
    inc0 = 1'b1;
    push(0, "first_acc", 0, 0, 0, 0, 1);
    cyc();
    inc0 = 1'b0;
    push(0, "first_ptr", 1, 1, 0, 1, 0);

    // Wrap: remote follows the local pointer; synchronised view lags by two edges.
    cyc();
    rst = 1'b1;
    push(0, "rst3", 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      cyc();
      inc0 = (k < 16);
      rem0 = 4'(gtab[k % 16]);
      push(0, "wrap", gtab[k % 16], k % 8, 0, (k < 2) ? k : 2, (k < 16) ? 1 : 0);
    end
    cyc();
    inc0 = 1'b0;
    end_req = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL summary_timeout actual=no_summary expected=summary");
    $fatal(1);
  end

endmodule
